// File: rtl/banked_word_ram_adapter_pkg.sv
// Shared types, default geometry and the byte-merge helper for the banked word RAM adapter.
// The helper works on a wide word; callers widen and truncate to their own BRAM_WIDTH.
package banked_ram_pkg;

   typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WAIT, RMW_WR} state_t;

   localparam int DEF_WE_SIZE      = 4;
   localparam int DEF_BRAM_WIDTH   = 32;
   localparam int DEF_BANK_DEPTH   = 32768;
   localparam int DEF_NUM_BANKS    = 2;
   localparam int DEF_READ_LATENCY = 1;

   localparam int WORD_AW    = $clog2(DEF_BANK_DEPTH * DEF_NUM_BANKS);
   localparam int BANK_SEL_W = (DEF_NUM_BANKS > 1) ? $clog2(DEF_NUM_BANKS) : 1;
   localparam int BANK_AW    = $clog2(DEF_BANK_DEPTH);

   localparam int MERGE_BYTES = 32;
   localparam int MERGE_W     = MERGE_BYTES * 8;

   function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0]     old_word,
                                                     input logic [MERGE_W-1:0]     new_word,
                                                     input logic [MERGE_BYTES-1:0] we);
      logic [MERGE_W-1:0] merged;
      for (int i = 0; i < MERGE_BYTES; i++) begin
         merged[i*8 +: 8] = we[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/banked_word_ram_adapter_read_pipe.sv
// READ_LATENCY-deep {valid, bank} delay line that steers the matching bank's dout to the port.
// Shared with the dual-port adapter variant.
module ram_read_align_pipe
   import banked_ram_pkg::*;
#(
   parameter int NUM_BANKS    = DEF_NUM_BANKS,
   parameter int BRAM_WIDTH   = DEF_BRAM_WIDTH,
   parameter int READ_LATENCY = DEF_READ_LATENCY,
   parameter int BSW          = BANK_SEL_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue,
   input  logic [BSW-1:0]                  bank,
   input  logic [NUM_BANKS*BRAM_WIDTH-1:0] bank_dout,
   output logic [BRAM_WIDTH-1:0]           dout
);

   logic [READ_LATENCY-1:0] valid_q;
   logic [BSW-1:0]          bank_q [READ_LATENCY];

   // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) bank_q[i] <= '0;
      end else begin
         valid_q[0] <= issue;
         bank_q[0]  <= bank;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            bank_q[i]  <= bank_q[i-1];
         end
      end
   end

   // NOTE: dout gets a default before the loop so the mux never infers a latch.
   always_comb begin
      dout = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (valid_q[READ_LATENCY-1] && bank_q[READ_LATENCY-1] == BSW'(k))
            dout = bank_dout[k*BRAM_WIDTH +: BRAM_WIDTH];
      end
   end

endmodule

// File: rtl/banked_word_ram_adapter.sv
// Byte-enabled controller port onto NUM_BANKS word-wide single-write-enable banks.
// Define BYTE_RMW_EN for exact partial writes via a stalled read-modify-write; otherwise enables are OR-reduced.
module banked_word_ram_adapter
   import banked_ram_pkg::*;
#(
   parameter int WE_SIZE      = DEF_WE_SIZE,
   parameter int BRAM_WIDTH   = DEF_BRAM_WIDTH,
   parameter int BANK_DEPTH   = DEF_BANK_DEPTH,
   parameter int NUM_BANKS    = DEF_NUM_BANKS,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                                         in_clk,
   input  logic                                         in_rst,
   input  logic                                         in_en,
   input  logic [WE_SIZE-1:0]                           in_we,
   input  logic [$clog2(BANK_DEPTH*NUM_BANKS)+1:0]      in_addr,
   input  logic [BRAM_WIDTH-1:0]                        in_din,
   output logic [BRAM_WIDTH-1:0]                        in_dout,
   output logic                                         in_ready,
   output logic [NUM_BANKS-1:0]                         out_en,
   output logic [NUM_BANKS-1:0]                         out_we,
   output logic [$clog2(BANK_DEPTH)-1:0]                out_addr,
   output logic [BRAM_WIDTH-1:0]                        out_din,
   input  logic [NUM_BANKS*BRAM_WIDTH-1:0]              out_dout
);

   localparam int AW  = $clog2(BANK_DEPTH * NUM_BANKS);
   localparam int BAW = $clog2(BANK_DEPTH);
   localparam int BSW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   logic [AW-1:0]  word_addr;
   logic [BAW-1:0] req_addr;
   logic [BSW-1:0] req_bank;
   logic           rd_issue;
   logic           unused_addr;

   assign word_addr   = in_addr[AW+1:2];
   assign req_addr    = word_addr[BAW-1:0];
   assign req_bank    = (NUM_BANKS > 1) ? word_addr[AW-1 -: BSW] : '0;
   assign unused_addr = ^in_addr[1:0];
   assign rd_issue    = in_ready && in_en && (in_we == '0) && !in_rst;

`ifdef BYTE_RMW_EN
   state_t                  state, next_state;
   logic [1:0]              cnt;
   logic [BAW-1:0]          lat_addr;
   logic [BSW-1:0]          lat_bank;
   logic [BRAM_WIDTH-1:0]   lat_din;
   logic [WE_SIZE-1:0]      lat_we;
   logic [BRAM_WIDTH-1:0]   cap_word;
   logic [BRAM_WIDTH-1:0]   bank_word;
   logic [BRAM_WIDTH-1:0]   merged;
   logic                    partial;

   assign partial  = in_en && (in_we != '0) && (in_we != '1);
   assign in_ready = (state == IDLE);
   assign merged   = BRAM_WIDTH'(byte_merge(MERGE_W'(cap_word), MERGE_W'(lat_din), MERGE_BYTES'(lat_we)));

   always_ff @(posedge in_clk) begin
      if (in_rst) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (partial) next_state = RMW_RD;
         RMW_RD:   next_state = RMW_WAIT;
         RMW_WAIT: if (cnt == '0) next_state = RMW_WR;
         RMW_WR:   next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      bank_word = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (lat_bank == BSW'(k)) bank_word = out_dout[k*BRAM_WIDTH +: BRAM_WIDTH];
      end
   end

   // The bank holds its dout while out_en is low, so the word read in IDLE is still there in RMW_WAIT.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         cnt      <= '0;
         lat_addr <= '0;
         lat_bank <= '0;
         lat_din  <= '0;
         lat_we   <= '0;
         cap_word <= '0;
      end else begin
         case (state)
            IDLE: if (partial) begin
               lat_addr <= req_addr;
               lat_bank <= req_bank;
               lat_din  <= in_din;
               lat_we   <= in_we;
            end
            RMW_RD:   cnt <= 2'(READ_LATENCY - 1);
            RMW_WAIT: if (cnt == '0) cap_word <= bank_word;
                      else           cnt      <= cnt - 2'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      out_en   = '0;
      out_we   = '0;
      out_addr = req_addr;
      out_din  = in_din;
      case (state)
         IDLE: if (in_en) begin
            out_en[req_bank] = 1'b1;
            if (in_we == '1) out_we[req_bank] = 1'b1;
         end
         RMW_RD, RMW_WAIT: out_addr = lat_addr;
         RMW_WR: begin
            out_addr         = lat_addr;
            out_din          = merged;
            out_en[lat_bank] = 1'b1;
            out_we[lat_bank] = 1'b1;
         end
         default: ;
      endcase
      if (in_rst) begin
         out_en = '0;
         out_we = '0;
      end
   end
`else
   assign in_ready = 1'b1;

   always_comb begin
      out_en   = '0;
      out_we   = '0;
      out_addr = req_addr;
      out_din  = in_din;
      if (in_en && !in_rst) begin
         out_en[req_bank] = 1'b1;
         if (|in_we) out_we[req_bank] = 1'b1;
      end
   end
`endif

   ram_read_align_pipe #(
      .NUM_BANKS    (NUM_BANKS),
      .BRAM_WIDTH   (BRAM_WIDTH),
      .READ_LATENCY (READ_LATENCY),
      .BSW          (BSW)
   ) u_read_pipe (
      .clk       (in_clk),
      .rst       (in_rst),
      .issue     (rd_issue),
      .bank      (req_bank),
      .bank_dout (out_dout),
      .dout      (in_dout)
   );

endmodule

// File: tb/tb_banked_word_ram_adapter.sv
// Directed bench for banked_word_ram_adapter with a two-bank behavioural BRAM and a read scoreboard.
// Follows the RTL build: RMW scenarios when BYTE_RMW_EN is defined, legacy OR-reduced writes otherwise.
module tb_banked_word_ram_adapter;

   logic        clk = 1'b0;
   logic        in_rst;
   logic        in_en;
   logic [3:0]  in_we;
   logic [17:0] in_addr;
   logic [31:0] in_din;
   logic [31:0] in_dout;
   logic        in_ready;
   logic [1:0]  out_en;
   logic [1:0]  out_we;
   logic [14:0] out_addr;
   logic [31:0] out_din;
   logic [63:0] out_dout;

   int          tests = 0;
   int          fails = 0;
   int          we_seen = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   banked_word_ram_adapter dut (
      .in_clk   (clk),
      .in_rst   (in_rst),
      .in_en    (in_en),
      .in_we    (in_we),
      .in_addr  (in_addr),
      .in_din   (in_din),
      .in_dout  (in_dout),
      .in_ready (in_ready),
      .out_en   (out_en),
      .out_we   (out_we),
      .out_addr (out_addr),
      .out_din  (out_din),
      .out_dout (out_dout)
   );

   // Behavioural banks: one-cycle read latency, dout holds while disabled.
   logic [31:0] mem0 [int];
   logic [31:0] mem1 [int];
   logic [31:0] dq0 = '0;
   logic [31:0] dq1 = '0;
   assign out_dout = {dq1, dq0};

   always @(posedge clk) begin
      if (|out_we) we_seen++;
      if (out_en[0]) begin
         dq0 <= mem0.exists(int'(out_addr)) ? mem0[int'(out_addr)] : 32'h0;
         if (out_we[0]) mem0[int'(out_addr)] = out_din;
      end
      if (out_en[1]) begin
         dq1 <= mem1.exists(int'(out_addr)) ? mem1[int'(out_addr)] : 32'h0;
         if (out_we[1]) mem1[int'(out_addr)] = out_din;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; a read accepted this cycle is scored against the queue just after the edge.
   task automatic tick();
      bit issued;
      issued = in_en && (in_we == 4'h0) && in_ready && !in_rst;
      @(posedge clk);
      #1;
      if (issued) check("rd_data", in_dout, exp_q.pop_front());
   endtask

   task automatic do_write(input logic [17:0] addr, input logic [3:0] we, input logic [31:0] din);
      in_en   = 1'b1;
      in_we   = we;
      in_addr = addr;
      in_din  = din;
      tick();
      in_en = 1'b0;
      in_we = 4'h0;
   endtask

   task automatic do_read(input string tag, input logic [17:0] addr, input logic [1:0] exp_en,
                          input logic [31:0] exp_data);
      in_en   = 1'b1;
      in_we   = 4'h0;
      in_addr = addr;
      exp_q.push_back(exp_data);
      #1;
      check({tag, "_en"}, out_en, exp_en);
      tick();
      in_en = 1'b0;
   endtask

   initial begin
      int busy;
      int we_before;
      logic [31:0] wr_data;
      logic [14:0] wr_addr;
      logic [1:0]  wr_we;

      // Reset with a full write presented: nothing may reach the banks.
      in_rst = 1'b1; in_en = 1'b1; in_we = 4'hF; in_addr = 18'h20004; in_din = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("rst_out_en", out_en, 2'b00);
      check("rst_out_we", out_we, 2'b00);
      tick();
      in_rst = 1'b0; in_en = 1'b0; in_we = 4'h0;
      #1;
      check("rst_ready", in_ready, 1'b1);
      check("rst_dout", in_dout, 32'h0);

      // Full-word write passes straight through in the same cycle.
      in_en = 1'b1; in_we = 4'hF; in_addr = 18'h20004; in_din = 32'hDEADBEEF;
      #1;
      check("fw_addr", out_addr, 15'h0001);
      check("fw_en", out_en, 2'b10);
      check("fw_we", out_we, 2'b10);
      check("fw_din", out_din, 32'hDEADBEEF);
      check("fw_ready", in_ready, 1'b1);
      tick();
      in_en = 1'b0; in_we = 4'h0;

      do_write(18'h00004, 4'hF, 32'h12345678);
      do_write(18'h00008, 4'hF, 32'h11223344);
      do_write(18'h0000C, 4'hF, 32'h11223344);

      // Back-to-back reads alternating banks.
      do_read("rd_b1", 18'h20004, 2'b10, 32'hDEADBEEF);
      do_read("rd_b0", 18'h00004, 2'b01, 32'h12345678);
      do_read("rd_b1b", 18'h20004, 2'b10, 32'hDEADBEEF);
      do_read("rd_b0b", 18'h00004, 2'b01, 32'h12345678);

      // Disabled access with all enables set: banks untouched, no read data.
      in_en = 1'b0; in_we = 4'hF; in_addr = 18'h20004; in_din = 32'h0BAD_0BAD;
      #1;
      check("dis_en", out_en, 2'b00);
      check("dis_we", out_we, 2'b00);
      tick();
      check("dis_dout", in_dout, 32'h0);
      in_we = 4'h0;

`ifdef BYTE_RMW_EN
      // Partial write: read issued in IDLE, then ready low for the RMW.
      in_en = 1'b1; in_we = 4'b0010; in_addr = 18'h00008; in_din = 32'h0000AB00;
      #1;
      check("pw_rd_en", out_en, 2'b01);
      check("pw_rd_we", out_we, 2'b00);
      tick();
      in_en = 1'b0; in_we = 4'h0;
      busy = 0; wr_data = '0; wr_addr = '0; wr_we = '0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready) break;
         busy++;
         if (out_we != 2'b00) begin
            wr_data = out_din; wr_addr = out_addr; wr_we = out_we;
         end
         tick();
      end
      check("pw_busy", busy, 3);
      check("pw_wr_we", wr_we, 2'b01);
      check("pw_wr_addr", wr_addr, 15'h0002);
      check("pw_wr_data", wr_data, 32'h1122AB44);
      do_read("pw_rb", 18'h00008, 2'b01, 32'h1122AB44);

      // Two-byte merge on the same word.
      do_write(18'h00008, 4'b1001, 32'hAA0000BB);
      for (int i = 0; i < 10 && !in_ready; i++) tick();
      check("pw2_ready", in_ready, 1'b1);
      do_read("pw2_rb", 18'h00008, 2'b01, 32'hAA22ABBB);

      // Reset during RMW_WAIT aborts the pending write.
      we_before = we_seen;
      do_write(18'h0000C, 4'b0010, 32'h0000AB00);
      tick();
      in_rst = 1'b1;
      #1;
      check("abort_we", out_we, 2'b00);
      tick();
      in_rst = 1'b0;
      #1;
      check("abort_ready", in_ready, 1'b1);
      tick();
      tick();
      check("abort_no_write", we_seen, we_before);
      do_read("abort_rb", 18'h0000C, 2'b01, 32'h11223344);
`else
      // Legacy: a single enable becomes a one-cycle full-word write.
      in_en = 1'b1; in_we = 4'b0001; in_addr = 18'h00008; in_din = 32'h000000AA;
      #1;
      check("lg_en", out_en, 2'b01);
      check("lg_we", out_we, 2'b01);
      check("lg_din", out_din, 32'h000000AA);
      check("lg_ready", in_ready, 1'b1);
      tick();
      in_en = 1'b0; in_we = 4'h0;
      #1;
      check("lg_ready_after", in_ready, 1'b1);
      do_read("lg_rb", 18'h00008, 2'b01, 32'h000000AA);
`endif

      check("sb_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/banked_word_ram_adapter.md
Name: banked_word_ram_adapter

Overview:
Adapts one byte-addressed, byte-enabled BRAM controller port onto NUM_BANKS word-addressed, single-write-enable BRAM banks. This lets the sequencer instruction memory span all available block RAM.
- Bank select comes from the upper word-address bits.
- Read data is returned through a latency-matched bank-select pipeline.
- Partial-byte writes are performed as a stalled read-modify-write (RMW), so byte enables are honoured exactly instead of being OR-reduced.

Parameters:
WE_SIZE, 4, number of byte enables on the input port; must equal BRAM_WIDTH/8.
BRAM_WIDTH, 32, data width in bits of the input port and of every bank.
BANK_DEPTH, 32768, words per bank; power of two.
NUM_BANKS, 2, number of banks; power of two, ≥1.
READ_LATENCY, 1, cycles from bank address/enable to bank dout valid; 1 or 2.

Ports:
in_clk  input  1  single clock for the input port and all banks.
in_rst  input  1  synchronous, active-high reset.
in_en  input  1  access enable from the controller.
in_we  input  WE_SIZE  byte write enables.
in_addr  input  $clog2(BANK_DEPTH*NUM_BANKS)+2  byte address; bits [1:0] are ignored.
in_din  input  BRAM_WIDTH  write data.
in_dout  output  BRAM_WIDTH  read data.
in_ready  output  1  high = a request is accepted this cycle.
out_en  output  NUM_BANKS  per-bank enable, one-hot or zero.
out_we  output  NUM_BANKS  per-bank full-word write enable.
out_addr  output  $clog2(BANK_DEPTH)  word address, shared by all banks.
out_din  output  BRAM_WIDTH  write data, shared by all banks.
out_dout  input  NUM_BANKS*BRAM_WIDTH  flattened bank read data; bank k occupies bits [k*BRAM_WIDTH +: BRAM_WIDTH].

Behaviour:
- Clock and reset: one clock (in_clk). Reset (in_rst) is synchronous and active-high.
- Address split:
  - word address = in_addr[AW+1:2], with AW = $clog2(BANK_DEPTH*NUM_BANKS).
  - bank = upper $clog2(NUM_BANKS) bits of the word address.
  - out_addr = lower $clog2(BANK_DEPTH) bits of the word address.
  - NUM_BANKS=1 gives a zero-width bank field; bank 0 is always selected.
- State machine: states IDLE, RMW_RD, RMW_WAIT, RMW_WR.
  - in_ready = (state == IDLE).
  - Requests presented while in_ready is low are ignored; the controller holds its request.
- IDLE, combinational pass-through, no added latency:
  - in_en=1, in_we=0 (read): out_en[bank]=1, out_we=0.
  - in_en=1, in_we all ones (full-word write): out_en[bank]=1, out_we[bank]=1, out_din=in_din. Stays in IDLE.
  - in_en=1, in_we partial (nonzero, not all ones): latch addr, bank, din and we; drive a read to the bank; go to RMW_RD.
  - in_en=0: out_en=0 and out_we=0 regardless of in_we.
- RMW sequence, driven from the latched registers:
  - RMW_RD: out_en=0; counter loaded with READ_LATENCY-1, then RMW_WAIT. With READ_LATENCY=1 the wait is zero cycles and the state passes straight through.
  - RMW_WAIT: decrement the counter; at zero, capture the selected bank's dout.
  - RMW_WR: out_en[bank]=1, out_we[bank]=1. out_din takes byte i from the latched din where latched we[i]=1, otherwise from the captured word. Then return to IDLE.
  - in_ready is low for exactly READ_LATENCY+2 cycles per partial write.
- Read return:
  - A shift pipeline of depth READ_LATENCY carries {valid, bank} for each IDLE read.
  - in_dout = out_dout slice of the pipelined bank when its valid bit is set, else 0.
  - Back-to-back reads to alternating banks return the correct bank on every cycle.
- Reset values:
  - state=IDLE, in_ready=1 after the reset edge.
  - All pipeline valid/bank bits = 0, latched registers = 0, in_dout = 0.
  - out_en and out_we are forced to 0 during any cycle with in_rst=1.
- Reset mid-RMW: abort to IDLE; the pending write is never issued; out_we stays 0.
- Read of the address just written by an RMW: legal once in_ready is high. The bank write completes in RMW_WR, before the following IDLE cycle.

Optional Feature:
Macro BYTE_RMW_EN.
- Defined: partial writes use the RMW sequence above.
- Undefined: the state machine is compiled out and in_ready is tied to 1. Any nonzero in_we is OR-reduced into a single-cycle full-word write of in_din (legacy behaviour). Read path is unchanged.

Decomposition:
- Package banked_ram_pkg holds:
  - the state enum (IDLE, RMW_RD, RMW_WAIT, RMW_WR);
  - localparams for word-address width, bank-select width and bank-address width, derived from the module parameters;
  - a byte-merge function (old, new, we) returning the merged word.
- One sub-module: ram_read_align_pipe. It is the READ_LATENCY-deep {valid, bank} delay line and output mux, and is reused later by the dual-port variant.

Test Plan:
Common setup: NUM_BANKS=2, BANK_DEPTH=32768, READ_LATENCY=1, BYTE_RMW_EN defined unless stated.
1. Full-word write in_addr=0x20004, in_we=4'hF, in_din=0xDEADBEEF -> same cycle out_addr=0x0001, out_en=2'b10, out_we=2'b10, out_din=0xDEADBEEF, in_ready stays 1.
2. Read in_addr=0x20004 with bank1 dout=0xDEADBEEF and bank0 dout=0x12345678 -> one cycle later in_dout=0xDEADBEEF; a following read of 0x00004 returns 0x12345678 on the next cycle.
3. Partial write to word 0x11223344 at in_addr=0x00008, in_we=4'b0010, in_din=0x0000AB00 -> in_ready low 3 cycles; bank0 written 0x1122AB44 at out_addr=0x0002.
4. Assert in_rst during RMW_WAIT of scenario 3 -> out_we never asserted, word remains 0x11223344, in_ready=1 after reset.
5. BYTE_RMW_EN undefined, in_we=4'b0001, in_din=0x000000AA -> single-cycle full-word write of 0x000000AA, in_ready never low.
6. in_en=0 with in_we=4'hF -> out_en=0, out_we=0, and in_dout=0 on the following cycle.
